// File: rtl/w80386_bus_pkg.sv
// Shared types and constants for the w80386 system bus agent and its arbiter.
// Module-level widths are derived from each instance's parameters; the defaults here describe the standard CPU top.
package w80386_bus_pkg;

  localparam int DEFAULT_NUM_MASTERS = 2;
  localparam int DEFAULT_ADDR_WIDTH  = 32;
  localparam int DEFAULT_DATA_WIDTH  = 32;

  // Index width that stays at least one bit wide for a single master.
  function automatic int grant_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int GRANT_WIDTH = grant_width(DEFAULT_NUM_MASTERS);
  localparam int BE_WIDTH    = DEFAULT_DATA_WIDTH / 8;

  typedef logic [DEFAULT_ADDR_WIDTH-1:0] bus_addr_t;
  typedef logic [DEFAULT_DATA_WIDTH-1:0] bus_data_t;
  typedef logic [BE_WIDTH-1:0]           bus_be_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } agent_state_t;

  localparam logic [0:0] STATE_IDLE = 1'b0;
  localparam logic [0:0] STATE_BUSY = 1'b1;

endpackage

// File: rtl/w80386_rr_arbiter.sv
// Combinational round-robin arbiter; search starts at pointer, restricted to lock_owner while a lock is active.
module w80386_rr_arbiter
  import w80386_bus_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int GW          = grant_width(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [GW-1:0]          pointer,
  input  logic                   lock_active,
  input  logic [GW-1:0]          lock_owner,
  output logic [NUM_MASTERS-1:0] grant,
  output logic [GW-1:0]          grant_idx,
  output logic                   grant_valid
);

  logic [NUM_MASTERS-1:0] eligible;

  assign eligible = lock_active ? (req & (NUM_MASTERS'(1) << lock_owner)) : req;

  always_comb begin
    int idx;
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    idx         = 0;
    for (int off = 0; off < NUM_MASTERS; off++) begin
      idx = (int'(pointer) + off) % NUM_MASTERS;
      if (!grant_valid && eligible[idx]) begin
        grant_valid = 1'b1;
        grant[idx]  = 1'b1;
        grant_idx   = GW'(idx);
      end
    end
  end

endmodule

// File: rtl/w80386_bus_agent.sv
// System bus agent: arbitrates NUM_MASTERS core ports onto one downstream bus with
// round-robin grants, locked sequences and a BUSY-cycle response timeout.
module w80386_bus_agent
  import w80386_bus_pkg::*;
#(
  parameter int NUM_MASTERS    = 2,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                                clock,
  input  logic                                reset_n,
  input  logic [NUM_MASTERS-1:0]              m_valid,
  output logic [NUM_MASTERS-1:0]              m_ready,
  output logic [NUM_MASTERS-1:0]              m_error,
  input  logic [NUM_MASTERS-1:0]              m_write_enable,
  input  logic [NUM_MASTERS-1:0]              m_lock,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]   m_address,
  input  logic [NUM_MASTERS*DATA_WIDTH/8-1:0] m_byte_enable,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0]   m_write_data,
  output logic [DATA_WIDTH-1:0]               m_read_data,
  output logic                                bus_vaild,
  input  logic                                bus_ready,
  output logic                                bus_write_enable,
  output logic [ADDR_WIDTH-1:0]               bus_address,
  output logic [DATA_WIDTH/8-1:0]             bus_byte_enable,
  output logic [DATA_WIDTH-1:0]               bus_write_data,
  input  logic [DATA_WIDTH-1:0]               bus_read_data,
  output logic [0:0]                          debug_state
);

  // Handshake: a master holds m_valid and its request fields stable until it sees
  // m_ready (one-cycle pulse, qualified by m_error). Downstream, bus_vaild stays high
  // with stable bus_* until bus_ready is sampled high; then it drops the next cycle.

  localparam int GW = grant_width(NUM_MASTERS);
  localparam int BW = DATA_WIDTH / 8;
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] COUNT_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  logic [0:0]             state;
  logic [NUM_MASTERS-1:0] grant_reg;
  logic [GW-1:0]          grant_idx;
  logic [GW-1:0]          pointer;
  logic                   lock_valid;
  logic [GW-1:0]          lock_owner;
  logic [CW-1:0]          count;

  logic                   req_write_enable;
  logic [ADDR_WIDTH-1:0]  req_address;
  logic [BW-1:0]          req_byte_enable;
  logic [DATA_WIDTH-1:0]  req_write_data;

  logic [NUM_MASTERS-1:0] arb_grant;
  logic [GW-1:0]          arb_idx;
  logic                   arb_valid;
  logic                   lock_active;
  logic                   busy;
  logic                   timeout_hit;
  logic                   done;
  logic [GW-1:0]          next_pointer;

  // A held lock only restricts arbitration while its owner still asserts m_lock.
  assign lock_active = lock_valid && m_lock[lock_owner];

  w80386_rr_arbiter #(
    .NUM_MASTERS (NUM_MASTERS),
    .GW          (GW)
  ) u_arbiter (
    .req         (m_valid),
    .pointer     (pointer),
    .lock_active (lock_active),
    .lock_owner  (lock_owner),
    .grant       (arb_grant),
    .grant_idx   (arb_idx),
    .grant_valid (arb_valid)
  );

  assign busy         = (state == STATE_BUSY);
  assign timeout_hit  = busy && (TIMEOUT_CYCLES != 0) && !bus_ready && (count == COUNT_LAST);
  assign done         = busy && (bus_ready || timeout_hit);
  assign next_pointer = (grant_idx == GW'(NUM_MASTERS - 1)) ? '0 : grant_idx + GW'(1);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state            <= STATE_IDLE;
      grant_reg        <= '0;
      grant_idx        <= '0;
      pointer          <= '0;
      lock_valid       <= 1'b0;
      lock_owner       <= '0;
      count            <= '0;
      req_write_enable <= 1'b0;
      req_address      <= '0;
      req_byte_enable  <= '0;
      req_write_data   <= '0;
    end else begin
      case (state)
        STATE_IDLE: begin
          if (lock_valid && !m_lock[lock_owner]) lock_valid <= 1'b0;
          if (arb_valid) begin
            state            <= STATE_BUSY;
            grant_reg        <= arb_grant;
            grant_idx        <= arb_idx;
            req_write_enable <= m_write_enable[arb_idx];
            req_address      <= m_address[arb_idx*ADDR_WIDTH +: ADDR_WIDTH];
            req_byte_enable  <= m_byte_enable[arb_idx*BW +: BW];
            req_write_data   <= m_write_data[arb_idx*DATA_WIDTH +: DATA_WIDTH];
          end
        end
        STATE_BUSY: begin
          if (done) begin
            state <= STATE_IDLE;
            count <= '0;
            if (m_lock[grant_idx]) begin
              lock_valid <= 1'b1;
              lock_owner <= grant_idx;
            end else begin
              pointer <= next_pointer;
            end
          end else if (TIMEOUT_CYCLES != 0) begin
            count <= count + CW'(1);
          end
        end
        default: state <= STATE_IDLE;
      endcase
    end
  end

  assign bus_vaild        = busy;
  assign bus_write_enable = req_write_enable;
  assign bus_address      = req_address;
  assign bus_byte_enable  = req_byte_enable;
  assign bus_write_data   = req_write_data;

  // A timed-out transfer returns all ones so the core sees an obviously bogus value.
  assign m_ready     = done ? grant_reg : '0;
  assign m_error     = timeout_hit ? grant_reg : '0;
  assign m_read_data = !done ? '0 : (timeout_hit ? '1 : bus_read_data);
  assign debug_state = state;

endmodule

// File: tb/tb_w80386_bus_agent.sv
// Directed table-driven bench for w80386_bus_agent with two masters and a four-cycle timeout.
module tb_w80386_bus_agent;

  localparam int NM = 2;
  localparam int AW = 32;
  localparam int DW = 32;

  logic             clock;
  logic             reset_n;
  logic [NM-1:0]    m_valid, m_ready, m_error, m_write_enable, m_lock;
  logic [NM*AW-1:0] m_address;
  logic [NM*4-1:0]  m_byte_enable;
  logic [NM*DW-1:0] m_write_data;
  logic [DW-1:0]    m_read_data;
  logic             bus_vaild, bus_ready, bus_write_enable;
  logic [AW-1:0]    bus_address;
  logic [3:0]       bus_byte_enable;
  logic [DW-1:0]    bus_write_data, bus_read_data;
  logic [0:0]       debug_state;

  w80386_bus_agent #(
    .NUM_MASTERS    (NM),
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .m_valid          (m_valid),
    .m_ready          (m_ready),
    .m_error          (m_error),
    .m_write_enable   (m_write_enable),
    .m_lock           (m_lock),
    .m_address        (m_address),
    .m_byte_enable    (m_byte_enable),
    .m_write_data     (m_write_data),
    .m_read_data      (m_read_data),
    .bus_vaild        (bus_vaild),
    .bus_ready        (bus_ready),
    .bus_write_enable (bus_write_enable),
    .bus_address      (bus_address),
    .bus_byte_enable  (bus_byte_enable),
    .bus_write_data   (bus_write_data),
    .bus_read_data    (bus_read_data),
    .debug_state      (debug_state)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        rst;
    logic [1:0]  valid;
    logic [1:0]  we;
    logic [1:0]  lock;
    logic        br;
    logic [31:0] rdata;
    logic [1:0]  exp_ready;
    logic [1:0]  exp_error;
    logic        exp_bvalid;
    logic [31:0] exp_rdata;
    int          exp_gnt;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] addr_tab[NM];
  logic [3:0]  be_tab[NM];
  logic [31:0] data_tab[NM];
  int          checks;
  int          errors;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add_row(input logic rst, input logic [1:0] valid, input logic [1:0] we,
                         input logic [1:0] lock, input logic br, input logic [31:0] rdata,
                         input logic [1:0] exp_ready, input logic [1:0] exp_error,
                         input logic exp_bvalid, input logic [31:0] exp_rdata, input int exp_gnt);
    vec_t v;
    v.rst = rst; v.valid = valid; v.we = we; v.lock = lock; v.br = br; v.rdata = rdata;
    v.exp_ready = exp_ready; v.exp_error = exp_error; v.exp_bvalid = exp_bvalid;
    v.exp_rdata = exp_rdata; v.exp_gnt = exp_gnt;
    vecs.push_back(v);
  endtask

  task automatic check_bus_for(input string tag, input int g, input logic we);
    check({tag, " bus_address"}, 64'(bus_address), 64'(addr_tab[g]));
    check({tag, " bus_byte_enable"}, 64'(bus_byte_enable), 64'(be_tab[g]));
    check({tag, " bus_write_data"}, 64'(bus_write_data), 64'(data_tab[g]));
    check({tag, " bus_write_enable"}, 64'(bus_write_enable), 64'(we));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    addr_tab[0] = 32'h0000_1000; be_tab[0] = 4'b1111; data_tab[0] = 32'hDEAD_BEEF;
    addr_tab[1] = 32'h0000_2000; be_tab[1] = 4'b0011; data_tab[1] = 32'h1234_5678;
    m_address      = {addr_tab[1], addr_tab[0]};
    m_byte_enable  = {be_tab[1], be_tab[0]};
    m_write_data   = {data_tab[1], data_tab[0]};
    m_valid        = '0;
    m_write_enable = '0;
    m_lock         = '0;
    bus_ready      = 1'b0;
    bus_read_data  = '0;
    reset_n        = 1'b0;

    // single write from M0, bus_ready on the third BUSY cycle
    add_row(0, 2'b01, 2'b01, 2'b00, 0, 32'h0,         2'b00, 2'b00, 0, 32'h0,         -1);
    add_row(0, 2'b01, 2'b01, 2'b00, 0, 32'h0,         2'b00, 2'b00, 1, 32'h0,          0);
    add_row(0, 2'b01, 2'b01, 2'b00, 0, 32'h0,         2'b00, 2'b00, 1, 32'h0,          0);
    add_row(0, 2'b01, 2'b01, 2'b00, 1, 32'hCAFE_0001, 2'b01, 2'b00, 1, 32'hCAFE_0001,  0);
    add_row(0, 2'b00, 2'b01, 2'b00, 0, 32'h0,         2'b00, 2'b00, 0, 32'h0,         -1);
    // reset to bring pointer back to 0
    add_row(1, 2'b00, 2'b00, 2'b00, 0, 32'h0,         2'b00, 2'b00, 0, 32'h0,         -1);
    // both masters request continuously: grants 0,1,0,1
    add_row(0, 2'b11, 2'b01, 2'b00, 0, 32'h0,         2'b00, 2'b00, 0, 32'h0,         -1);
    add_row(0, 2'b11, 2'b01, 2'b00, 1, 32'h0000_00A0, 2'b01, 2'b00, 1, 32'h0000_00A0,  0);
    add_row(0, 2'b11, 2'b01, 2'b00, 0, 32'h0,         2'b00, 2'b00, 0, 32'h0,         -1);
    add_row(0, 2'b11, 2'b01, 2'b00, 1, 32'h0000_00A1, 2'b10, 2'b00, 1, 32'h0000_00A1,  1);
    add_row(0, 2'b11, 2'b01, 2'b00, 0, 32'h0,         2'b00, 2'b00, 0, 32'h0,         -1);
    add_row(0, 2'b11, 2'b01, 2'b00, 1, 32'h0000_00A2, 2'b01, 2'b00, 1, 32'h0000_00A2,  0);
    add_row(0, 2'b11, 2'b01, 2'b00, 0, 32'h0,         2'b00, 2'b00, 0, 32'h0,         -1);
    add_row(0, 2'b11, 2'b01, 2'b00, 1, 32'h0000_00A3, 2'b10, 2'b00, 1, 32'h0000_00A3,  1);
    add_row(0, 2'b00, 2'b01, 2'b00, 0, 32'h0,         2'b00, 2'b00, 0, 32'h0,         -1);
    // M1 locked reads x3 while M0 waits, then M0
    add_row(0, 2'b10, 2'b00, 2'b10, 0, 32'h0,         2'b00, 2'b00, 0, 32'h0,         -1);
    add_row(0, 2'b11, 2'b00, 2'b10, 1, 32'h0000_00B1, 2'b10, 2'b00, 1, 32'h0000_00B1,  1);
    add_row(0, 2'b11, 2'b00, 2'b10, 0, 32'h0,         2'b00, 2'b00, 0, 32'h0,         -1);
    add_row(0, 2'b11, 2'b00, 2'b10, 1, 32'h0000_00B2, 2'b10, 2'b00, 1, 32'h0000_00B2,  1);
    add_row(0, 2'b11, 2'b00, 2'b10, 0, 32'h0,         2'b00, 2'b00, 0, 32'h0,         -1);
    add_row(0, 2'b11, 2'b00, 2'b10, 1, 32'h0000_00B3, 2'b10, 2'b00, 1, 32'h0000_00B3,  1);
    add_row(0, 2'b01, 2'b00, 2'b00, 0, 32'h0,         2'b00, 2'b00, 0, 32'h0,         -1);
    add_row(0, 2'b01, 2'b00, 2'b00, 1, 32'h0000_00B4, 2'b01, 2'b00, 1, 32'h0000_00B4,  0);
    add_row(0, 2'b00, 2'b00, 2'b00, 0, 32'h0,         2'b00, 2'b00, 0, 32'h0,         -1);
    // timeout: M1 read, bus_ready never comes, error in 4th BUSY cycle
    add_row(0, 2'b10, 2'b00, 2'b00, 0, 32'h0,         2'b00, 2'b00, 0, 32'h0,         -1);
    add_row(0, 2'b10, 2'b00, 2'b00, 0, 32'h0BAD_0BAD, 2'b00, 2'b00, 1, 32'h0,          1);
    add_row(0, 2'b10, 2'b00, 2'b00, 0, 32'h0BAD_0BAD, 2'b00, 2'b00, 1, 32'h0,          1);
    add_row(0, 2'b10, 2'b00, 2'b00, 0, 32'h0BAD_0BAD, 2'b00, 2'b00, 1, 32'h0,          1);
    add_row(0, 2'b10, 2'b00, 2'b00, 0, 32'h0BAD_0BAD, 2'b10, 2'b10, 1, 32'hFFFF_FFFF,  1);
    add_row(0, 2'b00, 2'b00, 2'b00, 0, 32'h0,         2'b00, 2'b00, 0, 32'h0,         -1);
    // bus_ready coincides with timeout: normal completion wins
    add_row(0, 2'b01, 2'b00, 2'b00, 0, 32'h0,         2'b00, 2'b00, 0, 32'h0,         -1);
    add_row(0, 2'b01, 2'b00, 2'b00, 0, 32'h0,         2'b00, 2'b00, 1, 32'h0,          0);
    add_row(0, 2'b01, 2'b00, 2'b00, 0, 32'h0,         2'b00, 2'b00, 1, 32'h0,          0);
    add_row(0, 2'b01, 2'b00, 2'b00, 0, 32'h0,         2'b00, 2'b00, 1, 32'h0,          0);
    add_row(0, 2'b01, 2'b00, 2'b00, 1, 32'h5555_AAAA, 2'b01, 2'b00, 1, 32'h5555_AAAA,  0);
    add_row(0, 2'b00, 2'b00, 2'b00, 0, 32'h0,         2'b00, 2'b00, 0, 32'h0,         -1);

    // reset state
    repeat (2) @(negedge clock);
    check("reset m_ready", 64'(m_ready), 64'(0));
    check("reset m_error", 64'(m_error), 64'(0));
    check("reset bus_vaild", 64'(bus_vaild), 64'(0));
    check("reset m_read_data", 64'(m_read_data), 64'(0));
    check("reset bus_address", 64'(bus_address), 64'(0));
    check("reset bus_write_data", 64'(bus_write_data), 64'(0));
    check("reset bus_byte_enable", 64'(bus_byte_enable), 64'(0));
    check("reset state", 64'(debug_state), 64'(0));

    // driver: one table row per clock, sampled 1 ns after the falling edge
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clock);
      reset_n        = !vecs[i].rst;
      m_valid        = vecs[i].valid;
      m_write_enable = vecs[i].we;
      m_lock         = vecs[i].lock;
      bus_ready      = vecs[i].br;
      bus_read_data  = vecs[i].rdata;
      #1;
      check($sformatf("row%0d m_ready", i), 64'(m_ready), 64'(vecs[i].exp_ready));
      check($sformatf("row%0d m_error", i), 64'(m_error), 64'(vecs[i].exp_error));
      check($sformatf("row%0d bus_vaild", i), 64'(bus_vaild), 64'(vecs[i].exp_bvalid));
      check($sformatf("row%0d m_read_data", i), 64'(m_read_data), 64'(vecs[i].exp_rdata));
      if (vecs[i].exp_gnt >= 0)
        check_bus_for($sformatf("row%0d", i), vecs[i].exp_gnt, vecs[i].we[vecs[i].exp_gnt]);
    end

    // reset asserted asynchronously in the middle of a BUSY cycle
    @(negedge clock);
    m_valid = 2'b01; m_write_enable = 2'b01; m_lock = 2'b00; bus_ready = 1'b0;
    @(negedge clock);
    #1;
    check("midrst busy before", 64'(bus_vaild), 64'(1));
    #2;
    bus_ready = 1'b1; bus_read_data = 32'h1111_2222;
    reset_n = 1'b0;
    #1;
    check("midrst bus_vaild", 64'(bus_vaild), 64'(0));
    check("midrst m_ready", 64'(m_ready), 64'(0));
    check("midrst state", 64'(debug_state), 64'(0));
    m_valid = 2'b00; bus_ready = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    m_valid = 2'b11;
    #1;
    check("post-rst idle", 64'(bus_vaild), 64'(0));
    @(negedge clock);
    #1;
    check("post-rst bus_vaild", 64'(bus_vaild), 64'(1));
    check_bus_for("post-rst", 0, 1'b1);
    bus_ready = 1'b1; bus_read_data = 32'h0000_0077;
    #1;
    check("post-rst m_ready", 64'(m_ready), 64'(2'b01));
    check("post-rst m_read_data", 64'(m_read_data), 64'(32'h0000_0077));
    @(negedge clock);
    m_valid = 2'b00; bus_ready = 1'b0;
    #1;
    check("post-rst done", 64'(bus_vaild), 64'(0));

    // report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

endmodule
